sprite_palette_bank: RTL and testbench

SPRITE_PALETTE_BANK -- requirements
Module: sprite_palette_bank

---
 rtl/sprite_palette_bank.sv | 176 +++++++++++++++++
 tb/tb_sprite_palette_bank.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_bank.sv
// Palette RAM in flops with a 2-stage pixel lookup, per-frame palette/dim
// selection and a background clear engine that whitens one palette.
module sprite_palette_bank #(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned NUM_PAL    = 4,
  parameter int unsigned CH_W       = 4,
  parameter int unsigned TRANSP_IDX = 0
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       frame_start,
  input  logic [$clog2(NUM_PAL)-1:0] pal_sel,
  input  logic [1:0]                 dim,
  input  logic                       pix_valid,
  input  logic [IDX_W-1:0]           pix_idx,
  output logic                       pix_valid_o,
  output logic [CH_W-1:0]            red,
  output logic [CH_W-1:0]            green,
  output logic [CH_W-1:0]            blue,
  output logic                       transp,
  input  logic                       wr_valid,
  input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [3*CH_W-1:0]          wr_rgb,
  input  logic                       clr_valid,
  input  logic [$clog2(NUM_PAL)-1:0] clr_pal,
  output logic                       wr_ready
);

  localparam int unsigned PAL_W = $clog2(NUM_PAL);
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned RGB_W = 3 * CH_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [PAL_W-1:0]   tgt_q;
  logic               ready_q;

  logic [RGB_W-1:0]   mem_q [NUM_PAL][DEPTH];
  logic [PAL_W-1:0]   active_pal_q;
  logic [1:0]         active_dim_q;

  logic               s1_valid_q;
  logic [RGB_W-1:0]   s1_rgb_q;
  logic               s1_transp_q;
  logic [1:0]         s1_dim_q;

  logic               out_valid_q;
  logic [CH_W-1:0]    red_q, green_q, blue_q;
  logic               transp_q;
  logic [CH_W-1:0]    red_d, green_d, blue_d;

  logic               clr_fire;
  logic               wr_fire;

  // ready_q is only ever high in IDLE, so it doubles as the accept gate
  assign clr_fire = clr_valid & ready_q;
  assign wr_fire  = wr_valid & ready_q & ~clr_valid;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (clr_fire) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            tgt_q   <= clr_pal;
            ready_q <= 1'b0;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned p = 0; p < NUM_PAL; p++) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
          mem_q[p][e] <= '1;
        end
      end
    end else if (state_q == CLEAR) begin
      mem_q[tgt_q][cnt_q] <= '1;
    end else if (wr_fire) begin
      mem_q[wr_pal][wr_idx] <= wr_rgb;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_pal_q <= '0;
      active_dim_q <= '0;
    end else if (frame_start) begin
      active_pal_q <= pal_sel;
      active_dim_q <= dim;
    end
  end

  // Dim level travels with the pixel so a frame switch never splits a lookup
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_rgb_q    <= '0;
      s1_transp_q <= 1'b0;
      s1_dim_q    <= '0;
    end else begin
      s1_valid_q <= pix_valid;
      if (pix_valid) begin
        s1_rgb_q    <= mem_q[active_pal_q][pix_idx];
        s1_transp_q <= (pix_idx == IDX_W'(TRANSP_IDX));
        s1_dim_q    <= active_dim_q;
      end
    end
  end

  function automatic logic [CH_W-1:0] dim_ch(input logic [CH_W-1:0] c,
                                             input logic [1:0] d);
    case (d)
      2'd0:    return c;
      2'd1:    return c >> 1;
      2'd2:    return c >> 2;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    red_d   = dim_ch(s1_rgb_q[RGB_W-1 -: CH_W], s1_dim_q);
    green_d = dim_ch(s1_rgb_q[2*CH_W-1 -: CH_W], s1_dim_q);
    blue_d  = dim_ch(s1_rgb_q[CH_W-1:0], s1_dim_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      transp_q    <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        red_q    <= red_d;
        green_q  <= green_d;
        blue_q   <= blue_d;
        transp_q <= s1_transp_q;
      end
    end
  end

  assign pix_valid_o = out_valid_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign transp      = transp_q;
  assign wr_ready    = ready_q;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Scoreboard bench for sprite_palette_bank: a behavioural palette/controller
// model predicts each lookup at issue time; results are checked on output.
module tb_sprite_palette_bank;

  localparam int IDX_W = 4;
  localparam int NUM_PAL = 4;
  localparam int CH_W = 4;
  localparam int DEPTH = 16;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        frame_start = 1'b0;
  logic [1:0]  pal_sel = '0;
  logic [1:0]  dim = '0;
  logic        pix_valid = 1'b0;
  logic [3:0]  pix_idx = '0;
  logic        pix_valid_o;
  logic [3:0]  red, green, blue;
  logic        transp;
  logic        wr_valid = 1'b0;
  logic [1:0]  wr_pal = '0;
  logic [3:0]  wr_idx = '0;
  logic [11:0] wr_rgb = '0;
  logic        clr_valid = 1'b0;
  logic [1:0]  clr_pal = '0;
  logic        wr_ready;

  sprite_palette_bank #(.IDX_W(IDX_W), .NUM_PAL(NUM_PAL), .CH_W(CH_W), .TRANSP_IDX(0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pal_sel(pal_sel),
    .dim(dim), .pix_valid(pix_valid), .pix_idx(pix_idx), .pix_valid_o(pix_valid_o),
    .red(red), .green(green), .blue(blue), .transp(transp),
    .wr_valid(wr_valid), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
    .clr_valid(clr_valid), .clr_pal(clr_pal), .wr_ready(wr_ready)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] rgb;
    logic        t;
    int          due;
  } sb_t;

  sb_t         sbq[$];
  logic [11:0] mem_m [NUM_PAL][DEPTH];
  logic [1:0]  m_apal, m_adim, m_tgt;
  logic [3:0]  m_cnt;
  logic        m_clr, m_ready;
  logic [11:0] last_rgb;
  logic        last_t;
  logic        last_ready;
  int          n_total = 0;
  int          n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] dim_c(input logic [3:0] c, input logic [1:0] d);
    if (d == 2'd0) return c;
    if (d == 2'd1) return c / 2;
    if (d == 2'd2) return c / 4;
    return 4'h0;
  endfunction

  function automatic logic [11:0] dim_rgb(input logic [11:0] v, input logic [1:0] d);
    return {dim_c(v[11:8], d), dim_c(v[7:4], d), dim_c(v[3:0], d)};
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NUM_PAL; p++)
      for (int e = 0; e < DEPTH; e++) mem_m[p][e] = 12'hFFF;
    m_apal = '0; m_adim = '0; m_tgt = '0; m_cnt = '0;
    m_clr = 1'b0; m_ready = 1'b0;
    last_rgb = '0; last_t = 1'b0;
    sbq.delete();
  endtask

  task automatic idle_inputs();
    pix_valid = 1'b0; wr_valid = 1'b0; clr_valid = 1'b0; frame_start = 1'b0;
  endtask

  // One clock: predict lookup, advance model at the edge, check #1 later.
  task automatic step();
    sb_t e;
    if (pix_valid) begin
      e.rgb = dim_rgb(mem_m[m_apal][pix_idx], m_adim);
      e.t   = (pix_idx == 4'd0);
      e.due = cyc + 2;
      sbq.push_back(e);
    end
    @(posedge Clk);
    if (frame_start) begin
      m_apal = pal_sel;
      m_adim = dim;
    end
    if (m_clr) begin
      mem_m[m_tgt][m_cnt] = 12'hFFF;
      if (m_cnt == 4'hF) begin
        m_clr = 1'b0;
        m_ready = 1'b1;
      end
      m_cnt = m_cnt + 4'd1;
    end else if (m_ready && clr_valid) begin
      m_clr = 1'b1; m_cnt = '0; m_tgt = clr_pal; m_ready = 1'b0;
    end else begin
      if (m_ready && wr_valid) mem_m[wr_pal][wr_idx] = wr_rgb;
      m_ready = 1'b1;
    end
    #1;
    last_ready = wr_ready;
    check_eq("wr_ready", wr_ready, m_ready);
    if (pix_valid_o) begin
      if (sbq.size() == 0) begin
        check_eq("spurious_valid", pix_valid_o, 0);
      end else begin
        e = sbq.pop_front();
        check_eq("rgb", {red, green, blue}, e.rgb);
        check_eq("transp", transp, e.t);
        check_eq("latency", cyc, e.due);
        last_rgb = e.rgb;
        last_t = e.t;
      end
    end else begin
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        check_eq("missing_valid", pix_valid_o, 1);
        void'(sbq.pop_front());
      end
      check_eq("hold_rgb", {red, green, blue}, last_rgb);
      check_eq("hold_transp", transp, last_t);
    end
    @(negedge Clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset_n = 1'b0;
    #1;
    check_eq("rst_valid", pix_valid_o, 0);
    check_eq("rst_rgb", {red, green, blue}, 0);
    check_eq("rst_transp", transp, 0);
    check_eq("rst_wr_ready", wr_ready, 0);
    model_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic lookup(input logic [3:0] idx);
    pix_valid = 1'b1; pix_idx = idx;
    step();
    pix_valid = 1'b0;
  endtask

  task automatic write(input logic [1:0] p, input logic [3:0] i, input logic [11:0] v);
    wr_valid = 1'b1; wr_pal = p; wr_idx = i; wr_rgb = v;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic set_frame(input logic [1:0] p, input logic [1:0] d);
    pal_sel = p; dim = d; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && sbq.size() > 0; i++) step();
    check_eq("drain_empty", sbq.size(), 0);
  endtask

  task automatic sweep();
    pix_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      pix_idx = 4'(i);
      step();
    end
    pix_valid = 1'b0;
    drain();
  endtask

  initial begin
    int n_low;
    @(negedge Clk);
    do_reset();

    // Reset contents, transparency flag
    lookup(4'd5);
    lookup(4'd0);
    drain();

    // Write then read; same-cycle write and lookup returns old contents
    write(2'd0, 4'd2, 12'h6DF);
    lookup(4'd2);
    pix_valid = 1'b1; pix_idx = 4'd8;
    write(2'd0, 4'd8, 12'h000);
    lookup(4'd8);
    drain();

    // Palette and dim only change on frame_start
    write(2'd1, 4'd3, 12'h842);
    pal_sel = 2'd1; dim = 2'd1;
    lookup(4'd3);
    set_frame(2'd1, 2'd1);
    lookup(4'd3);
    set_frame(2'd1, 2'd3);
    lookup(4'd3);
    set_frame(2'd1, 2'd2);
    lookup(4'd3);
    set_frame(2'd0, 2'd0);
    drain();

    // Fill palette 2 with black, then clear it with writes hammering meanwhile
    for (int i = 0; i < DEPTH; i++) write(2'd2, 4'(i), 12'h000);
    clr_valid = 1'b1; clr_pal = 2'd2;
    step();
    clr_valid = 1'b0;
    n_low = last_ready ? 0 : 1;
    wr_valid = 1'b1; wr_pal = 2'd2; wr_idx = 4'd1; wr_rgb = 12'h123;
    pal_sel = 2'd2; frame_start = 1'b1;
    pix_valid = 1'b1; pix_idx = 4'd15;
    for (int i = 0; i < 40 && !last_ready; i++) begin
      step();
      frame_start = 1'b0;
      pix_idx = 4'(i);
      if (!last_ready) n_low++;
    end
    idle_inputs();
    check_eq("clear_busy_cycles", n_low, 16);
    drain();
    sweep();
    set_frame(2'd0, 2'd0);
    sweep();

    // Simultaneous clear and write: the write is dropped
    clr_valid = 1'b1; clr_pal = 2'd1;
    wr_valid = 1'b1; wr_pal = 2'd0; wr_idx = 4'd4; wr_rgb = 12'h111;
    step();
    idle_inputs();
    for (int i = 0; i < 40 && !last_ready; i++) step();
    check_eq("clear2_done", last_ready, 1);
    lookup(4'd4);
    set_frame(2'd1, 2'd0);
    lookup(4'd3);
    drain();

    // Reset pulse part way through a clear of palette 0
    write(2'd0, 4'd9, 12'h0A0);
    clr_valid = 1'b1; clr_pal = 2'd0;
    step();
    clr_valid = 1'b0;
    repeat (6) step();
    do_reset();
    step();
    sweep();
    set_frame(2'd1, 2'd0);
    lookup(4'd3);
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
